// File: rtl/wave_pc_table.sv
// Per-SIMD program-counter table: one PC, active bit and return-address stack
// per resident wave. Dispatch loads a slot; EXECUTE writes back the next PC.
module wave_pc_table #(
  parameter int PC_WIDTH      = 32,
  parameter int NUM_WAVES     = 4,
  parameter int WAVE_ID_WIDTH = (NUM_WAVES > 1) ? $clog2(NUM_WAVES) : 1,
  parameter int STACK_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [2:0]               simd_state,
  input  logic                     dispatch_valid,
  input  logic [WAVE_ID_WIDTH-1:0] dispatch_wave_id,
  input  logic [PC_WIDTH-1:0]      dispatch_start_pc,
  input  logic [WAVE_ID_WIDTH-1:0] exec_wave_id,
  input  logic                     branch_taken,
  input  logic                     call,
  input  logic                     ret,
  input  logic                     halt,
  input  logic [PC_WIDTH-1:0]      branch_target,
  input  logic [WAVE_ID_WIDTH-1:0] rd_wave_id,
  output logic [PC_WIDTH-1:0]      pc_out,
  output logic [NUM_WAVES-1:0]     wave_active,
  output logic [NUM_WAVES-1:0]     stack_overflow,
  output logic [NUM_WAVES-1:0]     stack_underflow
);

  localparam logic [2:0] ST_EXECUTE = 3'b101;
  localparam int         SPW        = $clog2(STACK_DEPTH + 1);

  logic [PC_WIDTH-1:0] pc_q    [NUM_WAVES];
  logic [SPW-1:0]      sp_q    [NUM_WAVES];
  logic [PC_WIDTH-1:0] stack_q [NUM_WAVES][STACK_DEPTH];
  logic [NUM_WAVES-1:0] active_q;
  logic [NUM_WAVES-1:0] ovf_q;
  logic [NUM_WAVES-1:0] unf_q;

  logic [NUM_WAVES-1:0] disp_hit;
  logic [NUM_WAVES-1:0] exec_hit;
  logic [PC_WIDTH-1:0]  pc_inc  [NUM_WAVES];
  logic [PC_WIDTH-1:0]  stk_top [NUM_WAVES];

  // Wave ids that match no slot (out of range) fall through as no-ops.
  // A dispatch to a slot suppresses any EXECUTE write-back to that slot.
  always_comb begin
    for (int w = 0; w < NUM_WAVES; w++) begin
      disp_hit[w] = enable && dispatch_valid &&
                    (dispatch_wave_id == WAVE_ID_WIDTH'(w));
      exec_hit[w] = enable && (simd_state == ST_EXECUTE) && active_q[w] &&
                    (exec_wave_id == WAVE_ID_WIDTH'(w)) && !disp_hit[w];
      pc_inc[w]   = pc_q[w] + PC_WIDTH'(1);
      stk_top[w]  = '0;
      for (int k = 0; k < STACK_DEPTH; k++) begin
        if (sp_q[w] == SPW'(k + 1)) stk_top[w] = stack_q[w][k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= '0;
      ovf_q    <= '0;
      unf_q    <= '0;
      for (int w = 0; w < NUM_WAVES; w++) begin
        pc_q[w] <= '0;
        sp_q[w] <= '0;
        for (int k = 0; k < STACK_DEPTH; k++) stack_q[w][k] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WAVES; w++) begin
        if (disp_hit[w]) begin
          pc_q[w]     <= dispatch_start_pc;
          active_q[w] <= 1'b1;
          sp_q[w]     <= '0;
          ovf_q[w]    <= 1'b0;
          unf_q[w]    <= 1'b0;
        end else if (exec_hit[w]) begin
          if (halt) begin
            active_q[w] <= 1'b0;
          end else if (ret) begin
            if (sp_q[w] != '0) begin
              pc_q[w] <= stk_top[w];
              sp_q[w] <= sp_q[w] - SPW'(1);
            end else begin
              pc_q[w]  <= pc_inc[w];
              unf_q[w] <= 1'b1;
            end
          end else if (call) begin
            if (sp_q[w] != SPW'(STACK_DEPTH)) begin
              for (int k = 0; k < STACK_DEPTH; k++) begin
                if (sp_q[w] == SPW'(k)) stack_q[w][k] <= pc_inc[w];
              end
              sp_q[w] <= sp_q[w] + SPW'(1);
              pc_q[w] <= branch_target;
            end else begin
              pc_q[w]  <= pc_inc[w];
              ovf_q[w] <= 1'b1;
            end
          end else if (branch_taken) begin
            pc_q[w] <= branch_target;
          end else begin
            pc_q[w] <= pc_inc[w];
          end
        end
      end
    end
  end

  always_comb begin
    pc_out = '0;
    for (int w = 0; w < NUM_WAVES; w++) begin
      if (rd_wave_id == WAVE_ID_WIDTH'(w)) pc_out = pc_q[w];
    end
  end

  assign wave_active     = active_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule

// File: tb/tb_wave_pc_table.sv
// Directed bench for wave_pc_table with a slot-level reference model and a
// per-cycle compare process, plus literal checks on hand-computed values.
module tb_wave_pc_table;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  simd_state = 3'b000;
  logic        dispatch_valid = 1'b0;
  logic [1:0]  dispatch_wave_id = 2'd0;
  logic [31:0] dispatch_start_pc = 32'd0;
  logic [1:0]  exec_wave_id = 2'd0;
  logic        branch_taken = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [1:0]  rd_wave_id = 2'd0;
  logic [31:0] pc_out;
  logic [3:0]  wave_active;
  logic [3:0]  stack_overflow;
  logic [3:0]  stack_underflow;

  int checks = 0;
  int errors = 0;
  bit model_valid = 1'b0;

  // Reference model: what each slot must hold.
  logic [31:0] m_pc  [4];
  logic [31:0] m_stk [4][4];
  int          m_depth [4];
  logic [3:0]  m_act, m_ovf, m_unf;

  wave_pc_table dut (
    .clk(clk), .rst(rst), .enable(enable), .simd_state(simd_state),
    .dispatch_valid(dispatch_valid), .dispatch_wave_id(dispatch_wave_id),
    .dispatch_start_pc(dispatch_start_pc), .exec_wave_id(exec_wave_id),
    .branch_taken(branch_taken), .call(call), .ret(ret), .halt(halt),
    .branch_target(branch_target), .rd_wave_id(rd_wave_id), .pc_out(pc_out),
    .wave_active(wave_active), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model update from the inputs sampled at the clock edge.
  task automatic model_apply();
    int e, d;
    bit dhit;
    logic [31:0] nxt;
    if (rst) begin
      for (int w = 0; w < 4; w++) begin
        m_pc[w] = 32'd0;
        m_depth[w] = 0;
      end
      m_act = 4'd0; m_ovf = 4'd0; m_unf = 4'd0;
      return;
    end
    if (!enable) return;
    e = int'(exec_wave_id);
    d = int'(dispatch_wave_id);
    dhit = dispatch_valid;
    if (simd_state == 3'b101 && m_act[e] && !(dhit && d == e)) begin
      nxt = m_pc[e] + 32'd1;
      if (halt) m_act[e] = 1'b0;
      else if (ret) begin
        if (m_depth[e] > 0) begin
          m_depth[e]--;
          m_pc[e] = m_stk[e][m_depth[e]];
        end else begin
          m_pc[e] = nxt; m_unf[e] = 1'b1;
        end
      end else if (call) begin
        if (m_depth[e] < 4) begin
          m_stk[e][m_depth[e]] = nxt;
          m_depth[e]++;
          m_pc[e] = branch_target;
        end else begin
          m_pc[e] = nxt; m_ovf[e] = 1'b1;
        end
      end else if (branch_taken) m_pc[e] = branch_target;
      else m_pc[e] = nxt;
    end
    if (dhit) begin
      m_pc[d] = dispatch_start_pc;
      m_act[d] = 1'b1; m_depth[d] = 0;
      m_ovf[d] = 1'b0; m_unf[d] = 1'b0;
    end
  endtask

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("pc_out_model", pc_out, m_pc[rd_wave_id]);
      check("wave_active_model", {28'd0, wave_active}, {28'd0, m_act});
      check("overflow_model", {28'd0, stack_overflow}, {28'd0, m_ovf});
      check("underflow_model", {28'd0, stack_underflow}, {28'd0, m_unf});
    end
  end

  // Driver: one full clock cycle of inputs.
  task automatic cyc(input bit r, input bit en, input logic [2:0] st,
                     input bit dv, input logic [1:0] dw, input logic [31:0] dpc,
                     input logic [1:0] ew, input bit br, input bit ca,
                     input bit re, input bit ha, input logic [31:0] tgt);
    @(negedge clk); #1;
    rst = r; enable = en; simd_state = st;
    dispatch_valid = dv; dispatch_wave_id = dw; dispatch_start_pc = dpc;
    exec_wave_id = ew; branch_taken = br; call = ca; ret = re; halt = ha;
    branch_target = tgt;
    @(posedge clk); #1;
    model_apply();
    model_valid = 1'b1;
  endtask

  task automatic ex(input logic [1:0] w, input bit br, input bit ca,
                    input bit re, input bit ha, input logic [31:0] tgt);
    cyc(0, 1, 3'b101, 0, 2'd0, 32'd0, w, br, ca, re, ha, tgt);
  endtask

  task automatic disp(input logic [1:0] w, input logic [31:0] spc);
    cyc(0, 1, 3'b000, 1, w, spc, 2'd0, 0, 0, 0, 0, 32'd0);
  endtask

  task automatic peek(input logic [1:0] w, input logic [31:0] exp, input string name);
    rd_wave_id = w; #1;
    check(name, pc_out, exp);
  endtask

  initial begin
    // Reset and dispatch
    cyc(1, 0, 3'b000, 0, 2'd0, 32'd0, 2'd0, 0, 0, 0, 0, 32'd0);
    cyc(1, 1, 3'b000, 0, 2'd0, 32'd0, 2'd0, 0, 0, 0, 0, 32'd0);
    peek(2'd0, 32'd0, "reset_pc");
    check("reset_active", {28'd0, wave_active}, 32'd0);
    disp(2'd2, 32'h40);
    check("dispatch_active", {28'd0, wave_active}, 32'h4);
    peek(2'd2, 32'h40, "dispatch_pc");
    for (int i = 0; i < 3; i++) ex(2'd2, 0, 0, 0, 0, 32'd0);
    peek(2'd2, 32'h43, "plain_exec_pc");

    // Call / return
    disp(2'd0, 32'h10);
    ex(2'd0, 0, 1, 0, 0, 32'h80);
    peek(2'd0, 32'h80, "call_pc");
    ex(2'd0, 0, 0, 0, 0, 32'd0);
    ex(2'd0, 0, 0, 0, 0, 32'd0);
    peek(2'd0, 32'h82, "after_call_pc");
    ex(2'd0, 0, 0, 1, 0, 32'd0);
    peek(2'd0, 32'h11, "ret_pc");
    ex(2'd0, 1, 0, 0, 0, 32'h1234);
    peek(2'd0, 32'h1234, "branch_pc");

    // Overflow
    disp(2'd0, 32'h0);
    for (int i = 0; i < 4; i++) ex(2'd0, 0, 1, 0, 0, 32'h100);
    peek(2'd0, 32'h100, "fourth_call_pc");
    check("no_ovf_yet", {28'd0, stack_overflow}, 32'h0);
    ex(2'd0, 0, 1, 0, 0, 32'h100);
    peek(2'd0, 32'h101, "fifth_call_pc");
    check("ovf_set", {28'd0, stack_overflow}, 32'h1);
    ex(2'd0, 0, 0, 1, 0, 32'd0); peek(2'd0, 32'h101, "ret1_pc");
    ex(2'd0, 0, 0, 1, 0, 32'd0); peek(2'd0, 32'h101, "ret2_pc");
    ex(2'd0, 0, 0, 1, 0, 32'd0); peek(2'd0, 32'h101, "ret3_pc");
    ex(2'd0, 0, 0, 1, 0, 32'd0); peek(2'd0, 32'h1, "ret4_pc");

    // Underflow and wrap
    disp(2'd3, 32'h5);
    ex(2'd3, 0, 0, 1, 0, 32'd0);
    peek(2'd3, 32'h6, "underflow_pc");
    check("unf_set", {28'd0, stack_underflow}, 32'h8);
    disp(2'd3, 32'hFFFF_FFFF);
    check("unf_cleared", {28'd0, stack_underflow}, 32'h0);
    ex(2'd3, 0, 0, 0, 0, 32'd0);
    peek(2'd3, 32'h0, "wrap_pc");

    // Halt and collision
    disp(2'd1, 32'h30);
    ex(2'd1, 0, 0, 0, 1, 32'd0);
    check("halt_active", {31'd0, wave_active[1]}, 32'h0);
    ex(2'd1, 0, 0, 0, 0, 32'd0);
    peek(2'd1, 32'h30, "halted_pc_hold");
    cyc(0, 1, 3'b101, 1, 2'd1, 32'h200, 2'd1, 1, 0, 0, 0, 32'h999);
    peek(2'd1, 32'h200, "collision_pc");
    check("collision_active", {31'd0, wave_active[1]}, 32'h1);
    cyc(0, 1, 3'b101, 1, 2'd2, 32'h500, 2'd1, 0, 0, 0, 0, 32'd0);
    peek(2'd1, 32'h201, "both_exec_pc");
    peek(2'd2, 32'h500, "both_disp_pc");

    // Enable low, non-EXECUTE state
    cyc(0, 0, 3'b101, 1, 2'd3, 32'h777, 2'd1, 1, 0, 0, 0, 32'h999);
    peek(2'd1, 32'h201, "enable_low_pc");
    peek(2'd3, 32'h0, "enable_low_disp");
    cyc(0, 1, 3'b100, 0, 2'd0, 32'd0, 2'd1, 0, 0, 0, 0, 32'd0);
    peek(2'd1, 32'h201, "non_exec_pc");

    // Reset mid call sequence, with enable low
    ex(2'd0, 0, 1, 0, 0, 32'h300);
    peek(2'd0, 32'h300, "pre_rst_call_pc");
    cyc(1, 0, 3'b101, 0, 2'd0, 32'd0, 2'd0, 0, 1, 0, 0, 32'h300);
    check("rst_active", {28'd0, wave_active}, 32'h0);
    check("rst_ovf", {28'd0, stack_overflow}, 32'h0);
    check("rst_unf", {28'd0, stack_underflow}, 32'h0);
    for (int w = 0; w < 4; w++) peek(2'(w), 32'h0, "rst_pc");
    cyc(0, 1, 3'b000, 0, 2'd0, 32'd0, 2'd0, 0, 0, 0, 0, 32'd0);

    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_pc_table.md
# wave_pc_table

Per-SIMD program-counter table holding one PC per resident wave (up to NUM_WAVES). It adds three things to the single-wave PC: per-wave dispatch with a start address, taken branches, and a per-wave call/return stack with sticky error flags. It sits between the wave dispatcher and the SIMD fetch stage. Fetch reads the PC of the selected wave, and the EXECUTE stage writes back the next PC of the wave it just executed.

## Interface
- PC_WIDTH, 32: width of every PC, target and stack entry.
- NUM_WAVES, 4: resident wave slots per SIMD (≥1).
- WAVE_ID_WIDTH, $clog2(NUM_WAVES) (min 1): width of wave-id ports.
- STACK_DEPTH, 4: return-address entries per wave (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  gates every state update; when low, all state holds.
- simd_state  in  3  SIMD stage; 3'b101 = EXECUTE.
- dispatch_valid  in  1  load a new wave into a slot this cycle.
- dispatch_wave_id  in  WAVE_ID_WIDTH  slot being loaded.
- dispatch_start_pc  in  PC_WIDTH  first PC of the new wave.
- exec_wave_id  in  WAVE_ID_WIDTH  wave whose EXECUTE result is written back.
- branch_taken  in  1  jump to branch_target.
- call  in  1  push PC+1, jump to branch_target.
- ret  in  1  pop return address into PC.
- halt  in  1  wave finished; slot becomes inactive.
- branch_target  in  PC_WIDTH  target for branch_taken/call.
- rd_wave_id  in  WAVE_ID_WIDTH  fetch read select.
- pc_out  out  PC_WIDTH  PC of rd_wave_id (combinational read).
- wave_active  out  NUM_WAVES  per-slot active bit.
- stack_overflow  out  NUM_WAVES  sticky per-wave overflow flag.
- stack_underflow  out  NUM_WAVES  sticky per-wave underflow flag.

## Operation
- Per slot w: pc[w], active[w], a stack of STACK_DEPTH entries, sp[w] (0..STACK_DEPTH), ovf[w], unf[w].
- Reset: all pc = 0, active = 0, sp = 0, flags = 0; pc_out = 0.
- Dispatch (enable && dispatch_valid) sets slot d: pc = dispatch_start_pc, active = 1, sp = 0, ovf = unf = 0.
- EXECUTE update happens when enable && simd_state==3'b101 && active[e], where e = exec_wave_id. Controls are evaluated in priority order; the first match applies:
  - halt: active = 0; pc holds.
  - ret, sp>0: pc = stack[sp-1], sp--.
  - ret, sp==0: pc = pc+1, unf = 1.
  - call, sp<STACK_DEPTH: stack[sp] = pc+1, sp++, pc = branch_target.
  - call, sp==STACK_DEPTH: pc = pc+1, ovf = 1; stack unchanged.
  - branch_taken: pc = branch_target.
  - none: pc = pc+1.
- Arithmetic: pc+1 is computed modulo 2^PC_WIDTH, so all-ones wraps to 0.
- EXECUTE on an inactive slot changes nothing. Any non-EXECUTE simd_state changes nothing.
- If dispatch and EXECUTE target the same slot in the same cycle, dispatch wins and the EXECUTE update is dropped. Updates to different slots both apply.
- Out-of-range wave ids (≥NUM_WAVES) are ignored for writes. pc_out reads 0 for them.
- Flags clear only on rst or on re-dispatch of that slot.

## Timing
- Every write takes effect at the clock edge. New pc, active and flags are visible on outputs the following cycle.
- pc_out is combinational from rd_wave_id and registered pc. Reading a slot that is being written returns the old value in that cycle.
- rst asserted mid-operation clears everything at the next edge, regardless of enable.
- With enable low, dispatch and EXECUTE are ignored and all outputs hold.

## Test plan
- Reset, dispatch: rst, then dispatch wave 2 with start 0x40 → next cycle wave_active=4'b0100, pc_out(rd=2)=0x40. Three EXECUTE cycles with no controls → 0x43.
- Branch, call/return: wave 0 at 0x10. call with target 0x80 → pc=0x80. Two plain EXECUTEs → 0x82. ret → 0x11.
- Overflow: STACK_DEPTH=4, issue 5 calls to target 0x100 starting from pc 0x0 → after 4th call pc=0x100, sp=4. 5th call: pc=0x101, stack_overflow[0]=1. Four rets → 0x101, 0x101, 0x101, 0x1 in sequence (stack held 0x1, 0x101, 0x101, 0x101).
- Underflow, wrap: ret with empty stack at pc 0x5 → pc=0x6, stack_underflow set. Re-dispatch clears it. pc=all-ones plus EXECUTE → 0.
- Halt, collision: halt wave 1 → active[1]=0, and further EXECUTE on it leaves pc unchanged. Dispatch wave 1 (start 0x200) in the same cycle as an EXECUTE branch on wave 1 → pc=0x200, active=1.
- Enable/reset: enable=0 with EXECUTE → no change. rst mid-call sequence → all pc=0, wave_active=0, flags=0.
